// File: rtl/ex_mem_stage_if.sv
// EX->MEM pipeline boundary signals: upstream handshake, downstream handshake, flush.
// The slave modport is the stage; the master modport is the surrounding pipeline.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [DATA_W-1:0] in_branch_address;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_store_data;
  logic [REG_W-1:0]  in_rd;
  logic              in_zero;
  logic [4:0]        in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_branch_address;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_W-1:0]  out_rd;
  logic              out_zero;
  logic [4:0]        out_ctrl;
  logic              out_take_branch;

  modport slave (
    input  in_valid, flush,
    input  in_branch_address, in_alu_result,
    input  in_store_data, in_rd, in_zero, in_ctrl,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_branch_address, out_alu_result,
    output out_store_data, out_rd, out_zero,
    output out_ctrl, out_take_branch
  );

  modport master (
    output in_valid, flush,
    output in_branch_address, in_alu_result,
    output in_store_data, in_rd, in_zero, in_ctrl,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_branch_address, out_alu_result,
    input  out_store_data, out_rd, out_zero,
    input  out_ctrl, out_take_branch
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer (registered in_ready).
// Define EX_MEM_BRANCH_EN to resolve taken branches on out_take_branch.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic            clk,
  input logic            rst_n,
  ex_mem_stage_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] baddr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
    logic [REG_W-1:0]  rd;
    logic              zero;
    logic [4:0]        ctrl;
  } bundle_t;

  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  bundle_t in_b;
  logic    main_v_q, main_v_d;
  logic    skid_v_q, skid_v_d;
  logic    in_xfer;

  assign in_b.baddr = bus.in_branch_address;
  assign in_b.alu   = bus.in_alu_result;
  assign in_b.sdata = bus.in_store_data;
  assign in_b.rd    = bus.in_rd;
  assign in_b.zero  = bus.in_zero;
  assign in_b.ctrl  = bus.in_ctrl;

  assign bus.in_ready = ~skid_v_q;
  assign in_xfer      = bus.in_valid & ~skid_v_q;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (in_xfer) begin
        main_d   = in_b;
        main_v_d = 1'b1;
      end
    end else if (bus.out_ready) begin
      // Skid drains first; in_ready was low, so no input competes.
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (in_xfer) begin
        main_d   = in_b;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d   = in_b;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign bus.out_valid          = main_v_q;
  assign bus.out_branch_address = main_q.baddr;
  assign bus.out_alu_result     = main_q.alu;
  assign bus.out_store_data     = main_q.sdata;
  assign bus.out_rd             = main_q.rd;
  assign bus.out_zero           = main_q.zero;
  assign bus.out_ctrl           = main_v_q ? main_q.ctrl : 5'b0;

`ifdef EX_MEM_BRANCH_EN
  assign bus.out_take_branch = main_v_q & main_q.ctrl[0] & main_q.zero;
`else
  assign bus.out_take_branch = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage: latency, streaming, skid stall,
// flush, branch resolve and asynchronous reset.
module tb_ex_mem_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ex_mem_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [4:0] ctrl,
                       input logic zero);
    bus.in_valid          = v;
    bus.in_alu_result     = alu;
    bus.in_branch_address = alu + 32'h100;
    bus.in_store_data     = ~alu;
    bus.in_rd             = rd;
    bus.in_ctrl           = ctrl;
    bus.in_zero           = zero;
  endtask

  logic exp_tb;

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef EX_MEM_BRANCH_EN
    exp_tb = 1'b1;
`else
    exp_tb = 1'b0;
`endif
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
    #2;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("rst_out_alu", 64'(bus.out_alu_result), 64'd0);
    chk("rst_take", 64'(bus.out_take_branch), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // single bundle, latency 1
    drive(1'b1, 32'h1234, 5'd7, 5'b10000, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
    chk("lat_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_alu", 64'(bus.out_alu_result), 64'h1234);
    chk("lat_baddr", 64'(bus.out_branch_address), 64'h1334);
    chk("lat_sdata", 64'(bus.out_store_data), 64'hFFFF_EDCB);
    chk("lat_rd", 64'(bus.out_rd), 64'd7);
    chk("lat_ctrl", 64'(bus.out_ctrl), 64'b10000);
    step();
    chk("bubble_valid", 64'(bus.out_valid), 64'd0);
    chk("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);

    // back-to-back stream, ctrl=0 still a valid bundle
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 5'(i), 5'b00000, 1'b0);
      chk("strm_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      chk("strm_valid", 64'(bus.out_valid), 64'd1);
      chk("strm_alu", 64'(bus.out_alu_result), 64'(i));
    end
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
    step();
    chk("strm_drain", 64'(bus.out_valid), 64'd0);

    // stall: A in main, B in skid
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd1, 5'b01000, 1'b0);
    step();
    chk("stl_a_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 32'hB, 5'd2, 5'b00100, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
    chk("stl_b_ready", 64'(bus.in_ready), 64'd0);
    chk("stl_hold_a", 64'(bus.out_alu_result), 64'hA);
    chk("stl_hold_ctrl", 64'(bus.out_ctrl), 64'b01000);
    step();
    chk("stl_hold2_a", 64'(bus.out_alu_result), 64'hA);
    chk("stl_hold2_v", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("stl_out_b", 64'(bus.out_alu_result), 64'hB);
    chk("stl_out_b_rd", 64'(bus.out_rd), 64'd2);
    chk("stl_ready_back", 64'(bus.in_ready), 64'd1);
    step();
    chk("stl_empty", 64'(bus.out_valid), 64'd0);

    // flush with two held and C offered
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd1, 5'b10000, 1'b0);
    step();
    drive(1'b1, 32'hB, 5'd2, 5'b10000, 1'b0);
    step();
    chk("fl_full", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    drive(1'b1, 32'hC, 5'd3, 5'b10000, 1'b0);
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("fl_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_c", 64'(bus.out_valid), 64'd0);
    end

    // branch resolve
    drive(1'b1, 32'h40, 5'd0, 5'b00001, 1'b1);
    step();
    drive(1'b1, 32'h44, 5'd0, 5'b00001, 1'b0);
    chk("br_zero_reg", 64'(bus.out_zero), 64'd1);
    chk("br_taken", 64'(bus.out_take_branch), 64'(exp_tb));
    step();
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
    chk("br_nz", 64'(bus.out_take_branch), 64'd0);
    chk("br_nz_zero", 64'(bus.out_zero), 64'd0);
    step();
    chk("br_bubble", 64'(bus.out_take_branch), 64'd0);

    // async reset during stall with skid full
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd4, 5'b10001, 1'b1);
    step();
    drive(1'b1, 32'h22, 5'd5, 5'b10001, 1'b1);
    step();
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
    chk("ar_full", 64'(bus.in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_alu", 64'(bus.out_alu_result), 64'd0);
    chk("ar_rd", 64'(bus.out_rd), 64'd0);
    chk("ar_zero", 64'(bus.out_zero), 64'd0);
    chk("ar_ready", 64'(bus.in_ready), 64'd1);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h55, 5'd9, 5'b11000, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
    chk("ar_post_valid", 64'(bus.out_valid), 64'd1);
    chk("ar_post_alu", 64'(bus.out_alu_result), 64'h55);
    chk("ar_post_ctrl", 64'(bus.out_ctrl), 64'b11000);
    step();
    chk("ar_post_drain", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of branch_address, alu_result, store_data.
REQ-002 SHALL have parameter REG_W, default 5, width of destination register index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream EX holds a valid bundle.
REQ-006 in_ready  output  1  stage can accept a bundle this cycle.
REQ-007 flush  input  1  discard all held bundles.
REQ-008 in_branch_address, in_alu_result, in_store_data  input  DATA_W each  EX data payload.
REQ-009 in_rd  input  REG_W  destination register.
REQ-010 in_zero  input  1  ALU zero flag.
REQ-011 in_ctrl  input  5  {reg_write, mem_to_reg, mem_read, mem_write, branch}, bit 4 = reg_write.
REQ-012 out_valid  output  1  MEM-side bundle valid.
REQ-013 out_ready  input  1  MEM stage accepts bundle.
REQ-014 out_branch_address, out_alu_result, out_store_data, out_rd, out_zero, out_ctrl  output  widths as inputs  registered payload.
REQ-015 out_take_branch  output  1  branch resolved taken (see Configuration).

Function
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 Storage SHALL be two entries: main register (drives outputs) and skid register.
REQ-018 in_ready SHALL equal NOT skid-valid, decoded from registered state only (no combinational path from out_ready).
REQ-019 Empty main, input transfer: bundle SHALL appear on outputs with out_valid=1 the next cycle (latency 1).
REQ-020 Main valid, out_ready=1, input transfer: main SHALL load new bundle, out_valid stays 1 (full throughput, one bundle per cycle).
REQ-021 Main valid, out_ready=0, input transfer: bundle SHALL go to skid; in_ready=0 next cycle.
REQ-022 Main transfers out, skid valid: skid SHALL move to main next cycle; in_ready returns to 1.
REQ-023 While out_valid=1 and out_ready=0, all out_* SHALL hold stable and out_valid SHALL not drop (except flush/reset).
REQ-024 Bundle order SHALL be preserved; no bundle lost or duplicated.
REQ-025 flush SHALL have priority over all transfers: next cycle main and skid invalid, in_ready=1; the input offered in the flush cycle is dropped.
REQ-026 out_ctrl SHALL read 5'b0 whenever out_valid=0 (bubble); data outputs may hold last values.
REQ-027 in_valid with in_ctrl=0 SHALL be treated as an ordinary valid bundle.

Reset
REQ-028 rst_n low SHALL immediately clear main/skid valid, all out_* to 0, out_take_branch 0, in_ready 1.
REQ-029 Reset asserted mid-operation SHALL discard held bundles; first transfer accepted on the first rising edge with rst_n high.

Configuration
REQ-030 Macro EX_MEM_BRANCH_EN: defined -> out_take_branch = out_valid && out_ctrl[0] && out_zero.
REQ-031 Not defined -> out_take_branch tied 0; out_zero still registered; port list unchanged.

Verification
REQ-032 Reset, then in_valid=1 with alu_result=0x0000_1234, rd=5'd7, ctrl=5'b10000, out_ready=1 -> next cycle out_valid=1, out_alu_result=0x1234, out_rd=7, out_ctrl=5'b10000.
REQ-033 Stream 8 bundles (alu_result=1..8) back-to-back, out_ready=1 -> outputs 1..8 on consecutive cycles, in_ready constantly 1.
REQ-034 Send A=0xA, B=0xB with out_ready=0 -> in_ready=0 after B; out holds A; raise out_ready -> A then B, in_ready back to 1.
REQ-035 Two bundles held, pulse flush with in_valid=1 (C=0xC) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears.
REQ-036 EX_MEM_BRANCH_EN defined, ctrl=5'b00001, zero=1 -> out_take_branch=1; zero=0 -> 0; macro undefined -> always 0.
REQ-037 Drop rst_n mid-stall with skid full -> outputs 0 asynchronously, in_ready=1; after release, new bundle passes with latency 1.
